instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Instruction fetch unit for the single-issue MIPS core: it owns the program counter, requests instruction words from instruction memory over a req/ack handshake, and presents each word to the instruction decoder. It receives the decoder's control-flow outputs (`dobranch`, `dojump`) plus a jump-register target from the datapath, and from them computes the next PC. It is the producer end of the decoder's `instr` input.

## Interface

- `RESET_PC`, default 32'h0000_0000: PC loaded on reset; must be word-aligned.

- `clk`  in  1  core clock; all state updates on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  byte address of requested word; always word-aligned.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  instruction word; valid only when `imem_ack`=1.
- `instr`  out  32  current instruction to the decoder.
- `instr_valid`  out  1  `instr` holds a fetched, not-yet-retired word.
- `instr_ready`  in  1  downstream retires `instr` this cycle.
- `pc`  out  32  address of `instr`.
- `pc_plus4`  out  32  `pc`+4, used as the link value for `jal`.
- `dobranch`  in  1  decoder: take PC-relative branch for current `instr`.
- `dojump`  in  1  decoder: take absolute jump for current `instr`.
- `jr_sel`  in  1  jump is register-indirect (`jr`); qualifies `dojump`.
- `jr_target`  in  32  register value for `jr`.
- `misalign`  out  1  sticky: a `jr` target had nonzero bits [1:0].
- `instret`  out  32  count of retired instructions.

## Operation

- The FSM has three states. Reset state is START.
  - START: `imem_req`=0. On the next clock it goes to FETCH.
  - FETCH: `imem_req`=1 and `imem_addr`=`pc`. On a clock with `imem_ack`=1, the unit registers `instr`<=`imem_rdata` and goes to HOLD.
  - HOLD: `instr_valid`=1 and `imem_req`=0. On a clock with `instr_ready`=1, the unit updates `pc`, increments `instret`, and goes to FETCH.
- `imem_ack` is ignored outside FETCH. `instr_ready` is ignored outside HOLD.
- Control inputs (`dobranch`, `dojump`, `jr_sel`, `jr_target`) are sampled only on the retiring clock (HOLD with `instr_ready`=1).
- Next-PC priority, highest first. All arithmetic is 32-bit modulo 2^32.
  1. `dojump`&`jr_sel`: next PC = {`jr_target`[31:2],2'b00}. If `jr_target`[1:0]≠0, set `misalign`.
  2. `dojump`: next PC = {`pc_plus4`[31:28], `instr`[25:0], 2'b00}.
  3. `dobranch`: next PC = `pc_plus4` + (sign-extend(`instr`[15:0]) << 2).
  4. Otherwise: next PC = `pc_plus4`.
- `dobranch` and `dojump` asserted together: the jump wins.
- `jr_sel` without `dojump` has no effect.
- `pc_plus4` is combinational from `pc`. PC wraps from 32'hFFFF_FFFC to 0.
- `instret` wraps from 32'hFFFF_FFFF to 0.
- `misalign` is cleared only by reset.

## Timing

- Reset values:
  - state=START, `pc`=`RESET_PC`, `instr`=0.
  - `instr_valid`=0, `imem_req`=0, `imem_addr`=`RESET_PC`.
  - `misalign`=0, `instret`=0.
- Reset asserted mid-fetch or mid-hold: all state returns to reset values immediately. A pending memory ack is dropped.
- `imem_req` and `imem_addr` are stable while in FETCH until ack.
- `instr`, `pc`, and `instr_valid` are stable while in HOLD until ready.
- Latency, with memory ack in the same cycle as req:
  - First `instr_valid` occurs 2 clocks after reset release (START→FETCH→HOLD).
  - Steady throughput is one instruction per 2 clocks when `instr_ready` is held high.
- Memory wait states: each cycle with `imem_ack`=0 in FETCH adds one cycle.
- Downstream stall: each cycle with `instr_ready`=0 in HOLD adds one cycle.
- The redirect takes effect on the first FETCH after retirement. No wrong-path fetch ever occurs, so there are no flush cycles.

## Test plan

- **Reset and sequential fetch.** `RESET_PC`=0, memory acks immediately, `instr_ready`=1, no branches.
  - Required: fetch addresses 0, 4, 8, 12 in successive FETCH cycles.
  - Required: `instret`=3 after the third retirement.
  - Required: `imem_req`=0 throughout reset.
- **Taken branch.**
  - Negative offset: `pc`=32'h100, `instr`[15:0]=16'hFFFE, `dobranch`=1 at retirement. Required: next `imem_addr`=32'h0FC.
  - Positive offset: `instr`[15:0]=16'h0003 from `pc`=32'h100. Required: next `imem_addr`=32'h110.
- **Jump and priority.**
  - Absolute jump: `pc`=32'hF000_0010, `instr`=32'h0800_0040, `dojump`=1. Required: next `imem_addr`=32'hF000_0100.
  - Jump over branch: same jump with `dobranch`=1 also asserted. Required: identical result.
- **`jr` with misaligned target.** `dojump`=1, `jr_sel`=1, `jr_target`=32'h0000_2006.
  - Required: next `imem_addr`=32'h2004.
  - Required: `misalign`=1 from the next cycle, staying high until reset.
- **Handshake stalls.** Hold `imem_ack`=0 for 3 cycles, then hold `instr_ready`=0 for 4 cycles.
  - Required: `imem_addr` is constant during the ack wait.
  - Required: `instr`, `pc`, and `instr_valid`=1 are constant during the ready stall.
  - Required: exactly one retirement (`instret` increments by 1).
- **Reset mid-operation.** Assert `reset_n`=0 asynchronously in HOLD with `pc`=32'h40.
  - Required: `instr_valid`, `imem_req`, `instret`, and `misalign` go to 0 without waiting for a clock edge, and `pc`=`RESET_PC`.
  - Required: after release, the first fetch is at `RESET_PC`.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instr_fetch_unit
//  Description : Program counter owner for the single-issue MIPS core. Fetches
//                one instruction word at a time over a req/ack handshake,
//                holds it for the decoder until retired, and computes the next
//                PC from the decoder's branch/jump/jr controls.
//  Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    input  logic        dobranch,
    input  logic        dojump,
    input  logic        jr_sel,
    input  logic [31:0] jr_target,
    output logic        misalign,
    output logic [31:0] instret
);

    localparam logic [1:0] c_START = 2'd0;
    localparam logic [1:0] c_FETCH = 2'd1;
    localparam logic [1:0] c_HOLD  = 2'd2;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic        w_imem_req;
    logic        w_instr_valid;
    logic        w_load_instr;
    logic        w_retire;

    logic [31:0] r_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instret;
    logic        r_misalign;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_branch_off;
    logic [31:0] w_next_pc;
    logic        w_jr_misalign;

    // State register; asynchronous reset drops any in-flight fetch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_START;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; ack only matters in FETCH, ready only in HOLD.
    always_comb begin
        w_next_state  = r_state;
        w_imem_req    = 1'b0;
        w_instr_valid = 1'b0;
        w_load_instr  = 1'b0;
        w_retire      = 1'b0;
        case (r_state)
            c_START: begin
                w_next_state = c_FETCH;
            end
            c_FETCH: begin
                w_imem_req = 1'b1;
                if (imem_ack) begin
                    w_load_instr = 1'b1;
                    w_next_state = c_HOLD;
                end
            end
            c_HOLD: begin
                w_instr_valid = 1'b1;
                if (instr_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = c_FETCH;
                end
            end
            default: begin
                w_next_state = c_START;
            end
        endcase
    end

    // Next-PC selection: jr beats absolute jump beats branch beats fall-through.
    always_comb begin
        w_pc_plus4    = r_pc + 32'd4;
        w_branch_off  = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
        w_jr_misalign = 1'b0;
        w_next_pc     = w_pc_plus4;
        if (dojump && jr_sel) begin
            w_next_pc     = {jr_target[31:2], 2'b00};
            w_jr_misalign = (jr_target[1:0] != 2'b00);
        end else if (dojump) begin
            w_next_pc = {w_pc_plus4[31:28], r_instr[25:0], 2'b00};
        end else if (dobranch) begin
            w_next_pc = w_pc_plus4 + w_branch_off;
        end
    end

    // Datapath registers: capture on ack, advance PC and counters on retire.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc       <= RESET_PC;
            r_instr    <= 32'h0000_0000;
            r_instret  <= 32'h0000_0000;
            r_misalign <= 1'b0;
        end else begin
            if (w_load_instr) begin
                r_instr <= imem_rdata;
            end
            if (w_retire) begin
                r_pc      <= w_next_pc;
                r_instret <= r_instret + 32'd1;
                if (w_jr_misalign) begin
                    r_misalign <= 1'b1;
                end
            end
        end
    end

    assign imem_req    = w_imem_req;
    assign imem_addr   = r_pc;
    assign instr       = r_instr;
    assign instr_valid = w_instr_valid;
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign misalign    = r_misalign;
    assign instret     = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_fetch_unit
//  Description : Directed self-checking bench for instr_fetch_unit. Expected
//                fetch addresses are queued when a retirement is driven and
//                popped when the unit next requests memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        dobranch;
    logic        dojump;
    logic        jr_sel;
    logic [31:0] jr_target;
    logic        misalign;
    logic [31:0] instret;

    int          checks;
    int          errors;
    logic [31:0] exp_q[$];
    logic [31:0] r_saved_instret;

    instr_fetch_unit #(.RESET_PC(c_RESET_PC)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .dobranch    (dobranch),
        .dojump      (dojump),
        .jr_sel      (jr_sel),
        .jr_target   (jr_target),
        .misalign    (misalign),
        .instret     (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so a stuck run still terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    // Entered at a negedge in FETCH: compare address against the scoreboard,
    // insert wait states, then ack with the given word.
    task automatic fetch(input logic [31:0] word, input int waits);
        logic [31:0] expa;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            expa = 32'hxxxx_xxxx;
        end else begin
            expa = exp_q.pop_front();
        end
        check("fetch_req", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, expa);
        for (int i = 0; i < waits; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr_stable", imem_addr, expa);
        end
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("hold_valid", {31'd0, instr_valid}, 32'd1);
        check("hold_instr", instr, word);
        check("hold_pc", pc, expa);
    endtask

    // Entered at a negedge in HOLD: retire with given controls; queue next PC.
    task automatic retire(input logic br, input logic jmp, input logic jrs,
                          input logic [31:0] jrt, input logic [31:0] exp_next);
        dobranch    = br;
        dojump      = jmp;
        jr_sel      = jrs;
        jr_target   = jrt;
        instr_ready = 1'b1;
        exp_q.push_back(exp_next);
        @(negedge clk);
        instr_ready = 1'b0;
        dobranch    = 1'b0;
        dojump      = 1'b0;
        jr_sel      = 1'b0;
        jr_target   = 32'h0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        dobranch    = 1'b0;
        dojump      = 1'b0;
        jr_sel      = 1'b0;
        jr_target   = 32'h0;

        // Reset values and no request while reset is held.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_req", {31'd0, imem_req}, 32'd0);
        end
        check("reset_pc", pc, c_RESET_PC);
        check("reset_addr", imem_addr, c_RESET_PC);
        check("reset_instr", instr, 32'h0);
        check("reset_valid", {31'd0, instr_valid}, 32'd0);
        check("reset_misalign", {31'd0, misalign}, 32'd0);
        check("reset_instret", instret, 32'd0);

        reset_n = 1'b1;
        exp_q.push_back(c_RESET_PC);
        @(negedge clk);                         // START -> FETCH

        // Sequential fetch.
        fetch(32'h0000_0000, 0);
        check("pc_plus4", pc_plus4, 32'd4);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'd4);
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'd8);
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'd12);
        check("instret_3", instret, 32'd3);

        // j 0x100 from low memory.
        fetch(32'h0800_0040, 0);
        retire(1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0100);

        // Branch with negative offset.
        fetch(32'h1000_FFFE, 0);
        retire(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_00FC);

        // Aligned jr back to 0x100; no misalign.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0100);
        check("jr_aligned_misalign", {31'd0, misalign}, 32'd0);

        // Branch with positive offset.
        fetch(32'h1000_0003, 0);
        retire(1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_0110);

        // Reach 0xF000_0010, then absolute jump keeps upper nibble.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b1, 1'b1, 32'hF000_0010, 32'hF000_0010);
        fetch(32'h0800_0040, 0);
        retire(1'b0, 1'b1, 1'b0, 32'h0, 32'hF000_0100);

        // Same jump with branch also asserted: jump wins.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b1, 1'b1, 32'hF000_0010, 32'hF000_0010);
        fetch(32'h0800_0040, 0);
        retire(1'b1, 1'b1, 1'b0, 32'h0, 32'hF000_0100);

        // Misaligned jr target.
        fetch(32'h0000_0000, 0);
        check("pre_misalign", {31'd0, misalign}, 32'd0);
        retire(1'b0, 1'b1, 1'b1, 32'h0000_2006, 32'h0000_2004);
        check("misalign_set", {31'd0, misalign}, 32'd1);

        // jr_sel without dojump is a plain fall-through.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b0, 1'b1, 32'h0000_5000, 32'h0000_2008);
        check("misalign_sticky", {31'd0, misalign}, 32'd1);

        // Memory wait states, then downstream stall.
        fetch(32'h1234_5678, 3);
        r_saved_instret = instret;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, 32'h1234_5678);
            check("stall_pc", pc, 32'h0000_2008);
            check("stall_instret", instret, r_saved_instret);
        end
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_200C);
        check("stall_one_retire", instret, r_saved_instret + 32'd1);

        // PC wrap from the top of the address space.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        fetch(32'h0000_0000, 0);
        check("wrap_plus4", pc_plus4, 32'h0);
        retire(1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000);

        // Move to 0x40 and assert reset mid-hold.
        fetch(32'h0000_0000, 0);
        retire(1'b0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_0040);
        fetch(32'h1111_2222, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_valid", {31'd0, instr_valid}, 32'd0);
        check("async_req", {31'd0, imem_req}, 32'd0);
        check("async_instret", instret, 32'd0);
        check("async_misalign", {31'd0, misalign}, 32'd0);
        check("async_pc", pc, c_RESET_PC);
        imem_ack = 1'b1;                       // ack during reset must be ignored
        @(negedge clk);
        check("reset_hold_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b0;
        reset_n  = 1'b1;
        exp_q.push_back(c_RESET_PC);
        @(negedge clk);
        fetch(32'h0000_0000, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
